branch_predictor_btb: RTL and testbench

//  Parametrised branch predictor for the next-generation 5-stage RV32 pipeline.

---
 rtl/branch_predictor_btb_if.sv | 31 +++
 rtl/branch_predictor_btb.sv | 122 ++++++++++++
 tb/tb_branch_predictor_btb.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// rtl/branch_predictor_btb_if.sv - fetch lookup and EX resolution bundle of the BTB predictor
interface branch_predictor_btb_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] fetch_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;

  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_is_ctrl;
  logic            upd_is_jump;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_tgt;
  logic            mispredict;
  logic [XLEN-1:0] correct_pc;

  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_is_ctrl, upd_is_jump, upd_taken,
           upd_target, upd_pred_taken, upd_pred_tgt,
    input  pred_taken, pred_target, mispredict, correct_pc
  );

  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_is_ctrl, upd_is_jump, upd_taken,
           upd_target, upd_pred_taken, upd_pred_tgt,
    output pred_taken, pred_target, mispredict, correct_pc
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped BTB with 2-bit counters, init walk and statistics
module branch_predictor_btb #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 4,
  parameter int TAG_W = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_req,
  branch_predictor_btb_if.slave  bp,
  output logic                   ready,
  output logic [CNT_W-1:0]       branch_cnt,
  output logic [CNT_W-1:0]       mispred_cnt
);
  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];
  logic             jmp_q   [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (flush_req) begin
      state_d = ST_INIT;
      ptr_d   = '0;
    end else begin
      case (state_q)
        ST_INIT: begin
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == {IDX_W{1'b1}}) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  assign ready = (state_q == ST_RUN);

  // Fetch lookup reads only registered state, so a same-cycle update is seen next cycle
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx         = bp.fetch_pc[IDX_W+1:2];
  assign f_tag         = bp.fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign f_hit         = ready & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
  assign bp.pred_taken  = f_hit & (jmp_q[f_idx] | cnt_q[f_idx][1]);
  assign bp.pred_target = bp.pred_taken ? tgt_q[f_idx] : '0;

  assign bp.mispredict = bp.upd_valid &
                         ((bp.upd_taken != bp.upd_pred_taken) |
                          (bp.upd_taken & (bp.upd_pred_tgt != bp.upd_target)));
  assign bp.correct_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + XLEN'(4);

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;

  assign u_idx = bp.upd_pc[IDX_W+1:2];
  assign u_tag = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      valid_q[ptr_q] <= 1'b0;
    end else if (!rst && bp.upd_valid) begin
      if (bp.upd_is_ctrl) begin
        if (u_hit) begin
          if (bp.upd_is_jump) begin
            jmp_q[u_idx] <= 1'b1;
            cnt_q[u_idx] <= 2'd3;
          end else if (bp.upd_taken) begin
            if (cnt_q[u_idx] != 2'd3) cnt_q[u_idx] <= cnt_q[u_idx] + 2'd1;
          end else begin
            if (cnt_q[u_idx] != 2'd0) cnt_q[u_idx] <= cnt_q[u_idx] - 2'd1;
          end
          if (bp.upd_taken) tgt_q[u_idx] <= bp.upd_target;
        end else if (bp.upd_taken) begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
          tgt_q[u_idx]   <= bp.upd_target;
          cnt_q[u_idx]   <= bp.upd_is_jump ? 2'd3 : 2'd2;
          jmp_q[u_idx]   <= bp.upd_is_jump;
        end
      end else if (valid_q[u_idx]) begin
        // A non-control instruction sharing the slot proves the entry stale
        valid_q[u_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (bp.upd_valid && bp.upd_is_ctrl && !(&branch_cnt))
        branch_cnt <= branch_cnt + 1'b1;
      if (bp.mispredict && !(&mispred_cnt))
        mispred_cnt <= mispred_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - scoreboard bench for branch_predictor_btb against a behavioural model
module tb_branch_predictor_btb;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush_req;
  logic        ready, ready_s;
  logic [31:0] branch_cnt, mispred_cnt;
  logic [3:0]  bc_s, mc_s;

  always #5 clk = ~clk;

  branch_predictor_btb_if #(.XLEN(32)) bp ();
  branch_predictor_btb_if #(.XLEN(32)) bp_s ();

  branch_predictor_btb #(.XLEN(32), .IDX_W(4), .TAG_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .bp(bp),
    .ready(ready), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predictor_btb #(.XLEN(32), .IDX_W(4), .TAG_W(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .flush_req(flush_req), .bp(bp_s),
    .ready(ready_s), .branch_cnt(bc_s), .mispred_cnt(mc_s)
  );

  typedef struct {
    bit          rdy;
    bit          ptaken;
    logic [31:0] ptgt;
    bit          chk_upd;
    bit          misp;
    logic [31:0] cpc;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
    logic [3:0]  bcs;
    logic [3:0]  mcs;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  bit          m_jmp   [16];
  int          init_left;
  longint      raw_b, raw_m;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc >> 6) % 256;
  endfunction

  function automatic bit model_pred(input logic [31:0] pc, output logic [31:0] tgt);
    int i;
    bit t;
    i = idx_of(pc);
    t = (init_left == 0) && m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_jmp[i] || m_cnt[i] >= 2);
    tgt = t ? m_tgt[i] : 32'h0;
    return t;
  endfunction

  function automatic void clear_model_table();
    for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input bit r, input bit fl, input logic [31:0] fpc,
                      input bit uv, input bit ctrl, input bit jump, input bit taken,
                      input logic [31:0] upc, input logic [31:0] utgt,
                      input bit ptk, input logic [31:0] ptg, input bit chk);
    exp_t        e;
    logic [31:0] dummy;
    bit          misp;
    int          i;
    bit          hit;
    @(posedge clk);
    #1;
    rst = r; flush_req = fl;
    bp.fetch_pc = fpc;   bp_s.fetch_pc = fpc;
    bp.upd_valid = uv;   bp_s.upd_valid = uv;
    bp.upd_is_ctrl = ctrl; bp_s.upd_is_ctrl = ctrl;
    bp.upd_is_jump = jump; bp_s.upd_is_jump = jump;
    bp.upd_taken = taken;  bp_s.upd_taken = taken;
    bp.upd_pc = upc;       bp_s.upd_pc = upc;
    bp.upd_target = utgt;  bp_s.upd_target = utgt;
    bp.upd_pred_taken = ptk; bp_s.upd_pred_taken = ptk;
    bp.upd_pred_tgt = ptg;   bp_s.upd_pred_tgt = ptg;

    misp = uv && ((taken != ptk) || (taken && ptg != utgt));
    if (chk) begin
      e.rdy     = (init_left == 0);
      e.ptaken  = model_pred(fpc, dummy);
      e.ptgt    = dummy;
      e.chk_upd = uv;
      e.misp    = misp;
      e.cpc     = taken ? utgt : upc + 32'd4;
      e.bcnt    = (raw_b > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(raw_b);
      e.mcnt    = (raw_m > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(raw_m);
      e.bcs     = (raw_b > 15) ? 4'hF : 4'(raw_b);
      e.mcs     = (raw_m > 15) ? 4'hF : 4'(raw_m);
      exp_q.push_back(e);
    end

    if (r) begin
      init_left = 16; raw_b = 0; raw_m = 0;
      clear_model_table();
    end else begin
      if (uv && ctrl) raw_b++;
      if (misp) raw_m++;
      if (fl) begin
        init_left = 16;
        clear_model_table();
      end else if (init_left > 0) begin
        init_left--;
      end else if (uv) begin
        i   = idx_of(upc);
        hit = m_valid[i] && (m_tag[i] == tag_of(upc));
        if (ctrl) begin
          if (hit) begin
            if (jump) begin
              m_jmp[i] = 1'b1; m_cnt[i] = 3;
            end else if (taken) begin
              m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
            end else begin
              m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
            if (taken) m_tgt[i] = utgt;
          end else if (taken) begin
            m_valid[i] = 1'b1; m_tag[i] = tag_of(upc); m_tgt[i] = utgt;
            m_cnt[i] = jump ? 3 : 2; m_jmp[i] = jump;
          end
        end else if (m_valid[i]) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input logic [31:0] fpc);
    step(0, 0, fpc, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
  endtask

  task automatic upd(input logic [31:0] fpc, input bit ctrl, input bit jump, input bit taken,
                     input logic [31:0] upc, input logic [31:0] utgt,
                     input bit ptk, input logic [31:0] ptg);
    step(0, 0, fpc, 1, ctrl, jump, taken, upc, utgt, ptk, ptg, 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ready", 64'(ready), 64'(e.rdy));
      check("ready_small", 64'(ready_s), 64'(e.rdy));
      check("pred_taken", 64'(bp.pred_taken), 64'(e.ptaken));
      check("pred_target", 64'(bp.pred_target), 64'(e.ptgt));
      check("branch_cnt", 64'(branch_cnt), 64'(e.bcnt));
      check("mispred_cnt", 64'(mispred_cnt), 64'(e.mcnt));
      check("branch_cnt_sat", 64'(bc_s), 64'(e.bcs));
      check("mispred_cnt_sat", 64'(mc_s), 64'(e.mcs));
      if (e.chk_upd) begin
        check("mispredict", 64'(bp.mispredict), 64'(e.misp));
        check("correct_pc", 64'(bp.correct_pc), 64'(e.cpc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, tgt, ptg, ftch;
    bit          ctrl, jump, taken, ptk;
    int          waited;
    init_left = 16; raw_b = 0; raw_m = 0;
    for (int k = 0; k < 16; k++) begin
      m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_cnt[k] = 0; m_jmp[k] = 0;
    end
    rst = 1'b1; flush_req = 1'b0;
    step(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    step(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);

    step(1, 0, 32'h40, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
    for (int k = 0; k < 18; k++) idle(32'h40);

    upd(32'h40, 1, 0, 1, 32'h40, 32'h20, 0, 32'h0);
    idle(32'h40);
    upd(32'h40, 1, 0, 0, 32'h40, 32'h0, 1, 32'h20);
    idle(32'h40);
    upd(32'h40, 1, 0, 1, 32'h40, 32'h20, 0, 32'h0);
    upd(32'h40, 1, 0, 1, 32'h40, 32'h20, 1, 32'h20);
    upd(32'h40, 1, 0, 0, 32'h40, 32'h0, 1, 32'h20);
    idle(32'h40);

    upd(32'h40, 0, 0, 0, 32'h440, 32'h0, 1, 32'h20);
    idle(32'h40);

    upd(32'h80, 1, 1, 1, 32'h80, 32'h100, 0, 32'h0);
    idle(32'h80);
    step(0, 1, 32'h80, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
    for (int k = 0; k < 18; k++) idle(32'h80);

    upd(32'h0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0);

    for (int k = 0; k < 20; k++)
      upd(32'h0, 1, 0, 1, 32'h200, 32'h300 + 32'(k * 4), 0, 32'h0);
    idle(32'h0);

    for (int n = 0; n < 3000; n++) begin
      pc    = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      ftch  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 49) == 0) pc = 32'hFFFF_FFFC;
      ctrl  = ($urandom_range(0, 9) < 8);
      jump  = ctrl && ($urandom_range(0, 4) == 0);
      taken = jump || ($urandom_range(0, 1) == 1);
      tgt   = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 1) == 1) begin
        ptk = model_pred(pc, ptg);
      end else begin
        ptk = $urandom_range(0, 1) == 1;
        ptg = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
      end
      if ($urandom_range(0, 499) == 0)
        step(1, 0, ftch, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 1);
      else
        step(0, $urandom_range(0, 199) == 0, ftch, $urandom_range(0, 3) != 0,
             ctrl, jump, taken, pc, tgt, ptk, ptg, 1);
    end
    step(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    n_chk++;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
